// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one SRAM-like memory port between the instruction-fetch requester and
// the data (load/store) requester. One transaction is in flight at a time.
// Data normally wins. Fetch wins once STARVE_MAX data grants in a row have been
// taken while a fetch was waiting.
//
// Handshake semantics (all interfaces):
//   - Requester side: *_req is a level. It is held, with its address/data
//     fields stable, until the matching *_data_ok pulse. *_data_ok is high for
//     exactly one cycle, and *_rdata is valid only in that cycle.
//   - Memory side: an address phase is accepted on a cycle where
//     mem_req & mem_addr_ok. mem_req and its fields stay constant until then.
//     Exactly one mem_data_ok cycle follows, for loads and for stores.
//     mem_addr_ok outside the address phase and mem_data_ok outside the
//     response wait are ignored.
//
// Ports:
//   clk, resetn                      clock (rising edge), async active-low reset
//   inst_req/inst_addr               fetch request in
//   inst_rdata/inst_data_ok/i_stall  fetch response and stall out
//   data_req/data_wr/data_wstrb/
//   data_addr/data_wdata             load/store request in
//   data_rdata/data_data_ok/d_stall  load/store response and stall out
//   mem_req/mem_wr/mem_wstrb/
//   mem_addr/mem_wdata               memory request out
//   mem_addr_ok/mem_data_ok/
//   mem_rdata                        memory handshake and response in
//   o_dbg_state                      current FSM state, for checkers
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        resetn,
  // instruction fetch requester
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_data_ok,
  output logic        i_stall,
  // data requester
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_data_ok,
  output logic        d_stall,
  // memory port
  output logic        mem_req,
  output logic        mem_wr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  // debug
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_grant_data;      // 1: data owns the port, 0: fetch owns it
  logic        w_grant_data_nxt;
  logic [3:0]  r_starve_cnt;      // data grants taken while a fetch was waiting
  logic [3:0]  w_starve_nxt;
  logic [31:0] r_rdata_q;
  logic        w_rdata_load;

  logic        w_in_addr;
  logic        w_in_done;
  logic        w_data_store;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= ST_IDLE;
      r_grant_data <= 1'b0;
      r_starve_cnt <= 4'd0;
      r_rdata_q    <= 32'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant_data <= w_grant_data_nxt;
      r_starve_cnt <= w_starve_nxt;
      if (w_rdata_load) begin
        r_rdata_q <= mem_rdata;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and arbitration
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt      = r_state;
    w_grant_data_nxt = r_grant_data;
    w_starve_nxt     = r_starve_cnt;
    w_rdata_load     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // Requests are only looked at here; the winner is registered so the
        // memory-side mux is stable for the whole address phase.
        if (data_req && inst_req && (r_starve_cnt == STARVE_LIM)) begin
          w_grant_data_nxt = 1'b0;
          w_starve_nxt     = 4'd0;
          w_state_nxt      = ST_ADDR;
        end else if (data_req) begin
          w_grant_data_nxt = 1'b1;
          if (inst_req) begin
            // Saturate rather than wrap so a fetch can never lose its turn.
            w_starve_nxt = (r_starve_cnt < STARVE_LIM) ? 4'(r_starve_cnt + 4'd1)
                                                       : r_starve_cnt;
          end else begin
            w_starve_nxt = 4'd0;
          end
          w_state_nxt = ST_ADDR;
        end else if (inst_req) begin
          w_grant_data_nxt = 1'b0;
          w_starve_nxt     = 4'd0;
          w_state_nxt      = ST_ADDR;
        end
      end

      ST_ADDR: begin
        if (mem_addr_ok) begin
          w_state_nxt = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (mem_data_ok) begin
          w_rdata_load = 1'b1;
          w_state_nxt  = ST_DONE;
        end
      end

      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign w_in_addr    = (r_state == ST_ADDR);
  assign w_in_done    = (r_state == ST_DONE);
  assign w_data_store = w_in_addr & r_grant_data & data_wr;

  // Fields come straight from the owner's inputs. The owner holds them stable
  // until data_ok, so they stay constant while mem_addr_ok is withheld.
  assign mem_req   = w_in_addr;
  assign mem_addr  = w_in_addr ? (r_grant_data ? data_addr : inst_addr) : 32'd0;
  assign mem_wr    = w_data_store;
  assign mem_wstrb = w_data_store ? data_wstrb : 4'b0000;
  assign mem_wdata = (w_in_addr & r_grant_data) ? data_wdata : 32'd0;

  assign inst_data_ok = w_in_done & ~r_grant_data;
  assign data_data_ok = w_in_done &  r_grant_data;
  assign inst_rdata   = inst_data_ok ? r_rdata_q : 32'd0;
  assign data_rdata   = data_data_ok ? r_rdata_q : 32'd0;

  assign i_stall = inst_req & ~inst_data_ok;
  assign d_stall = data_req & ~data_data_ok;

  assign o_dbg_state = r_state;

endmodule
